// File: rtl/irq_priority_ctrl_if.sv
// Handshake and request bundle between the interrupt controller and its consumer.
// master = controller side, slave = requester/consumer side.
interface irq_priority_ctrl_if;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_code;
    logic [7:0] pending;
    logic       timeout;

    modport master (
        input  req, mask_wr, mask_in, irq_ack,
        output irq_valid, irq_code, pending, timeout
    );

    modport slave (
        output req, mask_wr, mask_in, irq_ack,
        input  irq_valid, irq_code, pending, timeout
    );
endinterface

// File: rtl/irq_priority_ctrl.sv
// Eight-line interrupt controller: pending/mask registers, highest-index offer over valid/ack, offer timeout.
// Optional IRQ_EDGE_DETECT_EN: pending is set on rising edges of req instead of levels.
module irq_priority_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    irq_priority_ctrl_if.master  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    state_t        state_q, state_d;
    logic [2:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    pending_q, pending_d;
    logic [7:0]    mask_q, mask_d;
    logic          timeout_q, timeout_d;

    logic [7:0]    set_vec;
    logic [7:0]    clr_vec;
    logic [7:0]    eligible;
    logic [2:0]    sel_code;

`ifdef IRQ_EDGE_DETECT_EN
    logic [7:0] req_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
        end else begin
            req_q <= bus.req;
        end
    end

    // Holding req_q at zero through reset makes a line already high at release count as one edge.
    assign set_vec = bus.req & ~req_q;
`else
    assign set_vec = bus.req;
`endif

    assign eligible = pending_q & mask_q;

    always_comb begin
        sel_code = '0;
        for (int i = 0; i < 8; i++) begin
            if (eligible[i]) begin
                sel_code = 3'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        cnt_d     = cnt_q;
        clr_vec   = '0;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    code_d  = sel_code;
                    cnt_d   = '0;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.irq_ack) begin
                    clr_vec[code_q] = 1'b1;
                    state_d         = IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                    clr_vec[code_q] = 1'b1;
                    timeout_d       = 1'b1;
                    state_d         = IDLE;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Set is applied after clear so a re-request in the clearing cycle keeps the bit.
    assign pending_d = (pending_q & ~clr_vec) | set_vec;
    assign mask_d    = bus.mask_wr ? bus.mask_in : mask_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            cnt_q     <= '0;
            pending_q <= '0;
            mask_q    <= 8'hFF;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.irq_valid = (state_q == OFFER);
    assign bus.irq_code  = code_q;
    assign bus.pending   = pending_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
// Bench for irq_priority_ctrl: directed scenarios then random traffic, every cycle checked against a reference model.
module tb_irq_priority_ctrl;

    localparam int T = 16;
`ifdef IRQ_EDGE_DETECT_EN
    localparam bit EDGE = 1'b1;
`else
    localparam bit EDGE = 1'b0;
`endif

    logic clk;
    logic rst_n;
    irq_priority_ctrl_if bus();

    irq_priority_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: offer described by how many valid cycles it has shown so far.
    logic [7:0] m_pend, m_mask, m_reqp;
    bit         m_valid, m_to;
    int         m_code, m_shown;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [7:0] setv, clr, elig;
        if (!rst_n) begin
            m_pend = 8'h00; m_mask = 8'hFF; m_reqp = 8'h00;
            m_valid = 0; m_to = 0; m_code = 0; m_shown = 0;
        end else begin
            setv = EDGE ? (bus.req & ~m_reqp) : bus.req;
            clr  = 8'h00;
            m_to = 0;
            elig = m_pend & m_mask;
            if (m_valid) begin
                if (bus.irq_ack) begin
                    clr = 8'(1 << m_code);
                    m_valid = 0;
                end else if (T != 0 && m_shown == T) begin
                    clr = 8'(1 << m_code);
                    m_valid = 0;
                    m_to = 1;
                end else begin
                    m_shown++;
                end
            end else if (elig != 8'h00) begin
                m_code  = $clog2(int'(elig) + 1) - 1;
                m_valid = 1;
                m_shown = 1;
            end
            m_pend = (m_pend & ~clr) | setv;
            if (bus.mask_wr) m_mask = bus.mask_in;
            m_reqp = bus.req;
        end
    endtask

    task automatic check_model();
        chk("valid",   32'(bus.irq_valid), 32'(m_valid));
        chk("code",    32'(bus.irq_code),  32'(m_code));
        chk("pending", 32'(bus.pending),   32'(m_pend));
        chk("timeout", 32'(bus.timeout),   32'(m_to));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drain();
        bus.req = 8'h00;
        bus.mask_wr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.irq_ack = bus.irq_valid;
            tick();
        end
        bus.irq_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcnt;
        bit saw_to;

        rst_n = 1'b0;
        bus.req = 8'h00; bus.mask_wr = 1'b0; bus.mask_in = 8'h00; bus.irq_ack = 1'b0;
        #2;
        tick();
        tick();
        chk("rst_valid",   32'(bus.irq_valid), 0);
        chk("rst_code",    32'(bus.irq_code),  0);
        chk("rst_pending", 32'(bus.pending),   0);
        chk("rst_timeout", 32'(bus.timeout),   0);
        rst_n = 1'b1;
        tick();

        // Two lines at once: 5 then 2, one idle cycle between offers.
        bus.req = 8'h24; tick();
        chk("t1_pend0", 32'(bus.pending), 32'h24);
        chk("t1_valid0", 32'(bus.irq_valid), 0);
        bus.req = 8'h00; tick();
        chk("t1_valid1", 32'(bus.irq_valid), 1);
        chk("t1_code5", 32'(bus.irq_code), 5);
        tick(); tick(); tick();
        bus.irq_ack = 1'b1; tick();
        bus.irq_ack = 1'b0;
        chk("t1_gap", 32'(bus.irq_valid), 0);
        chk("t1_pend1", 32'(bus.pending), 32'h04);
        tick();
        chk("t1_code2", 32'(bus.irq_code), 2);
        chk("t1_valid2", 32'(bus.irq_valid), 1);
        bus.irq_ack = 1'b1; tick();
        bus.irq_ack = 1'b0;
        chk("t1_pend2", 32'(bus.pending), 32'h00);
        tick();

        // Masked line 7 stays pending but is never offered.
        bus.mask_wr = 1'b1; bus.mask_in = 8'h7F; tick();
        bus.mask_wr = 1'b0; bus.req = 8'h88; tick();
        bus.req = 8'h00; tick();
        chk("t2_code3", 32'(bus.irq_code), 3);
        chk("t2_pend", 32'(bus.pending), 32'h88);
        bus.irq_ack = 1'b1; tick();
        bus.irq_ack = 1'b0; tick(); tick();
        chk("t2_nooffer", 32'(bus.irq_valid), 0);
        chk("t2_pend80", 32'(bus.pending), 32'h80);
        bus.mask_wr = 1'b1; bus.mask_in = 8'hFF; tick();
        bus.mask_wr = 1'b0;
        drain();

        // Unacknowledged offer times out after exactly T valid cycles.
        bus.req = 8'h02; tick();
        bus.req = 8'h00;
        vcnt = 0; saw_to = 0;
        for (int i = 0; i < 40 && !saw_to; i++) begin
            tick();
            if (bus.irq_valid) vcnt++;
            if (bus.timeout) saw_to = 1;
        end
        chk("t3_seen_timeout", 32'(saw_to), 1);
        chk("t3_valid_cycles", 32'(vcnt), 32'(T));
        chk("t3_pend", 32'(bus.pending), 0);
        tick();
        chk("t3_pulse_1cyc", 32'(bus.timeout), 0);

        // Held line 6: level mode re-offers, edge mode waits for a new rising edge.
        bus.req = 8'h40; tick(); tick();
        chk("t4_code6", 32'(bus.irq_code), 6);
        bus.irq_ack = 1'b1; tick();
        bus.irq_ack = 1'b0;
        chk("t4_gap", 32'(bus.irq_valid), 0);
        tick();
`ifdef IRQ_EDGE_DETECT_EN
        chk("t4_no_reoffer", 32'(bus.irq_valid), 0);
        tick();
        chk("t4_no_reoffer2", 32'(bus.irq_valid), 0);
        bus.req = 8'h00; tick();
        bus.req = 8'h40; tick();
        tick();
        chk("t4_rise_reoffer", 32'(bus.irq_valid), 1);
        chk("t4_rise_code", 32'(bus.irq_code), 6);
`else
        chk("t4_reoffer", 32'(bus.irq_valid), 1);
        chk("t4_recode", 32'(bus.irq_code), 6);
`endif
        drain();

        // New req[7] in the ack cycle of code 4, then ack coinciding with the timeout cycle.
        bus.req = 8'h10; tick();
        bus.req = 8'h00; tick();
        chk("t5_code4", 32'(bus.irq_code), 4);
        bus.irq_ack = 1'b1; bus.req = 8'h80; tick();
        bus.irq_ack = 1'b0; bus.req = 8'h00;
        chk("t5_pend80", 32'(bus.pending), 32'h80);
        chk("t5_gap", 32'(bus.irq_valid), 0);
        tick();
        chk("t5_code7", 32'(bus.irq_code), 7);
        for (int i = 0; i < T - 1; i++) tick();
        chk("t5_still_valid", 32'(bus.irq_valid), 1);
        bus.irq_ack = 1'b1; tick();
        bus.irq_ack = 1'b0;
        chk("t5_no_timeout", 32'(bus.timeout), 0);
        chk("t5_valid_off", 32'(bus.irq_valid), 0);
        tick();

        // Reset in the middle of an offer.
        bus.mask_wr = 1'b1; bus.mask_in = 8'h0F; tick();
        bus.mask_wr = 1'b0; bus.req = 8'h11; tick();
        bus.req = 8'h00; tick();
        chk("t6_code0", 32'(bus.irq_code), 0);
        chk("t6_valid", 32'(bus.irq_valid), 1);
        rst_n = 1'b0; tick();
        rst_n = 1'b1;
        chk("t6_valid0", 32'(bus.irq_valid), 0);
        chk("t6_pend0", 32'(bus.pending), 0);
        chk("t6_to0", 32'(bus.timeout), 0);
        bus.req = 8'h80; tick();
        bus.req = 8'h00; tick();
        chk("t6_mask_ff", 32'(bus.irq_code), 7);
        drain();

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            bus.req     = 8'($urandom & $urandom & $urandom);
            bus.irq_ack = ($urandom_range(0, 3) == 0);
            bus.mask_wr = ($urandom_range(0, 15) == 0);
            bus.mask_in = 8'($urandom);
            rst_n       = ($urandom_range(0, 99) != 0);
            tick();
        end
        rst_n = 1'b1;
        bus.mask_wr = 1'b1; bus.mask_in = 8'hFF; tick();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
